// File: rtl/prach_avst_packer.sv
// prach_avst_packer: packs complex PRACH FFT samples into Avalon-ST beats and
// releases them through a packet-committed FIFO so only whole packets leave.
module prach_avst_packer #(
    parameter int unsigned IQ_WIDTH   = 16,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned CHN_WIDTH  = 8,
    parameter int unsigned PKT_LEN    = 1024,
    parameter int unsigned FIFO_DEPTH = 512
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [IQ_WIDTH-1:0] din_dr,
    input  logic signed [IQ_WIDTH-1:0] din_di,
    input  logic                       din_dv,
    input  logic [CHN_WIDTH-1:0]       din_chn,
    input  logic                       sync_in,
    output logic [DATA_WIDTH-1:0]      avst_source_data,
    output logic                       avst_source_valid,
    output logic [15:0]                avst_source_channel,
    output logic                       avst_source_startofpacket,
    output logic                       avst_source_endofpacket,
    input  logic                       avst_source_ready,
    output logic                       stat_drop,
    output logic                       stat_abort,
    output logic [15:0]                stat_drop_cnt
);
    localparam int unsigned SW  = 2 * IQ_WIDTH;
    localparam int unsigned SPB = DATA_WIDTH / SW;
    localparam int unsigned PB  = PKT_LEN / SPB;
    localparam int unsigned KW  = (SPB > 1) ? $clog2(SPB) : 1;
    localparam int unsigned BW  = (PB > 1) ? $clog2(PB) : 1;
    localparam int unsigned AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned PW  = AW + 1;
    // FIFO entry layout: {sop, eop, channel, data}
    localparam int unsigned EW  = DATA_WIDTH + CHN_WIDTH + 2;

    logic [KW-1:0]         kcnt_q, kcnt_d;
    logic [BW-1:0]         bcnt_q, bcnt_d;
    logic                  admit_q, admit_d;
    logic [CHN_WIDTH-1:0]  chn_q, chn_d;
    logic [DATA_WIDTH-1:0] pack_q, pack_d;
    logic                  wr_pend_q, wr_pend_d;
    logic [EW-1:0]         wr_ent_q, wr_ent_d;
    logic [PW-1:0]         wr_spec_q, wr_spec_d;
    logic [PW-1:0]         wr_commit_q, wr_commit_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic [15:0]           out_chn_q, out_chn_d;
    logic                  out_sop_q, out_sop_d;
    logic                  out_eop_q, out_eop_d;
    logic                  drop_q, drop_d;
    logic                  abort_q, abort_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;

    logic [EW-1:0]         mem_q [FIFO_DEPTH];

    logic [KW-1:0]         cur_k;
    logic [BW-1:0]         cur_b;
    logic                  partial;
    logic                  abort;
    logic                  sample0;
    logic [PW-1:0]         commit_nxt;
    logic [PW-1:0]         used;
    logic                  admit_ok;
    logic                  admit_cur;
    logic [CHN_WIDTH-1:0]  chn_cur;
    logic [EW-1:0]         rd_ent;
    logic                  load;

    // Write side: sample counting, admission, packing, commit and sync-abort rollback
    always_comb begin
        kcnt_d      = kcnt_q;
        bcnt_d      = bcnt_q;
        admit_d     = admit_q;
        chn_d       = chn_q;
        pack_d      = pack_q;
        wr_pend_d   = 1'b0;
        wr_ent_d    = wr_ent_q;
        wr_spec_d   = wr_spec_q;
        drop_d      = 1'b0;
        abort_d     = 1'b0;
        drop_cnt_d  = drop_cnt_q;

        cur_k      = sync_in ? '0 : kcnt_q;
        cur_b      = sync_in ? '0 : bcnt_q;
        partial    = (kcnt_q != '0) || (bcnt_q != '0);
        abort      = sync_in && admit_q && partial;
        sample0    = din_dv && (cur_k == '0) && (cur_b == '0);
        // A pending eop write commits this cycle; admission must see it to stay exact.
        commit_nxt = (wr_pend_q && wr_ent_q[EW-2]) ? wr_spec_q + PW'(1) : wr_commit_q;
        used       = commit_nxt - rd_ptr_q;
        admit_ok   = (PW'(FIFO_DEPTH) - used) >= PW'(PB);
        admit_cur  = sample0 ? admit_ok : admit_q;
        chn_cur    = (sample0 && admit_ok) ? din_chn : chn_q;

        wr_commit_d = commit_nxt;
        if (wr_pend_q) begin
            wr_spec_d = wr_spec_q + PW'(1);
        end
        if (abort) begin
            wr_spec_d = commit_nxt;
            admit_d   = 1'b0;
            abort_d   = 1'b1;
        end
        if (sync_in) begin
            kcnt_d = '0;
            bcnt_d = '0;
        end
        if (sample0) begin
            admit_d = admit_ok;
            if (admit_ok) begin
                chn_d     = din_chn;
                wr_spec_d = commit_nxt;
            end else begin
                drop_d = 1'b1;
                if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_d = drop_cnt_q + 16'd1;
                end
            end
        end
        if (din_dv) begin
            pack_d[SW*cur_k +: SW] = {din_dr, din_di};
            if (cur_k == KW'(SPB - 1)) begin
                kcnt_d    = '0;
                bcnt_d    = (cur_b == BW'(PB - 1)) ? '0 : cur_b + BW'(1);
                wr_pend_d = admit_cur;
                wr_ent_d  = {cur_b == '0, cur_b == BW'(PB - 1), chn_cur, pack_d};
            end else begin
                kcnt_d = cur_k + KW'(1);
                bcnt_d = cur_b;
            end
        end
    end

    // Read side: refill the output register from committed beats only
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_chn_d   = out_chn_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        rd_ptr_d    = rd_ptr_q;

        rd_ent = mem_q[rd_ptr_q[AW-1:0]];
        load   = (!out_valid_q || avst_source_ready) && (rd_ptr_q != wr_commit_q);
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = rd_ent[DATA_WIDTH-1:0];
            out_chn_d   = 16'(rd_ent[DATA_WIDTH +: CHN_WIDTH]);
            out_sop_d   = rd_ent[EW-1];
            out_eop_d   = rd_ent[EW-2];
            rd_ptr_d    = rd_ptr_q + PW'(1);
        end else if (avst_source_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Beat storage; contents are meaningless once the pointers are reset
    always_ff @(posedge clk) begin
        if (wr_pend_q) begin
            mem_q[wr_spec_q[AW-1:0]] <= wr_ent_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kcnt_q      <= '0;
            bcnt_q      <= '0;
            admit_q     <= 1'b0;
            chn_q       <= '0;
            pack_q      <= '0;
            wr_pend_q   <= 1'b0;
            wr_ent_q    <= '0;
            wr_spec_q   <= '0;
            wr_commit_q <= '0;
            rd_ptr_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_chn_q   <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            drop_q      <= 1'b0;
            abort_q     <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            kcnt_q      <= kcnt_d;
            bcnt_q      <= bcnt_d;
            admit_q     <= admit_d;
            chn_q       <= chn_d;
            pack_q      <= pack_d;
            wr_pend_q   <= wr_pend_d;
            wr_ent_q    <= wr_ent_d;
            wr_spec_q   <= wr_spec_d;
            wr_commit_q <= wr_commit_d;
            rd_ptr_q    <= rd_ptr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_chn_q   <= out_chn_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            drop_q      <= drop_d;
            abort_q     <= abort_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign avst_source_data          = out_data_q;
    assign avst_source_valid         = out_valid_q;
    assign avst_source_channel       = out_chn_q;
    assign avst_source_startofpacket = out_sop_q;
    assign avst_source_endofpacket   = out_eop_q;
    assign stat_drop                 = drop_q;
    assign stat_abort                = abort_q;
    assign stat_drop_cnt             = drop_cnt_q;

endmodule

// File: doc/prach_avst_packer.md
# prach_avst_packer

Parametrised store-and-forward packetiser at the output of the PRACH DSP chain. It sits after `prach_fft` in `clk_dsp` and gathers the per-channel complex FFT sample stream into `DATA_WIDTH`-bit Avalon-ST beats. Each beat is buffered in a packet-committed FIFO. Only complete packets are released, with start/end-of-packet framing and `avst_source_ready` backpressure, toward the eth/xRAN egress. It generalises the fixed 16-bit/128-bit/8-antenna output path with configurable widths, packet length and depth. It adds three behaviours: whole-packet admission control, sync-abort rollback and drop accounting.

## Interface
- `IQ_WIDTH`, 16: bits per I and per Q component.
- `DATA_WIDTH`, 128: output beat width; must be a multiple of 2*`IQ_WIDTH`. SPB = `DATA_WIDTH`/(2*`IQ_WIDTH`) samples per beat (default 4).
- `CHN_WIDTH`, 8: input channel tag width; must be ≤16.
- `PKT_LEN`, 1024: samples per packet; must be a multiple of SPB. PB = `PKT_LEN`/SPB beats per packet (default 256).
- `FIFO_DEPTH`, 512: FIFO depth in beats; must be a power of two and ≥ PB.

Ports:
- `clk` in 1: DSP clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `din_dr` in `IQ_WIDTH`: sample real part, signed.
- `din_di` in `IQ_WIDTH`: sample imaginary part, signed.
- `din_dv` in 1: input sample valid. There is no backpressure toward the input.
- `din_chn` in `CHN_WIDTH`: channel tag; sampled on packet sample 0 only.
- `sync_in` in 1: frame-start pulse; forces packet alignment.
- `avst_source_data` out `DATA_WIDTH`: packed beat.
- `avst_source_valid` out 1: beat valid.
- `avst_source_channel` out 16: zero-extended channel tag of the packet.
- `avst_source_startofpacket` out 1: first beat of a packet.
- `avst_source_endofpacket` out 1: last beat of a packet.
- `avst_source_ready` in 1: sink ready; ready latency 0.
- `stat_drop` out 1: one-cycle pulse when a packet is refused.
- `stat_abort` out 1: one-cycle pulse when a partial packet is discarded by `sync_in`.
- `stat_drop_cnt` out 16: refused-packet count; saturates at 0xFFFF.

## Operation
- **Sample counter** `scnt` (0..`PKT_LEN`-1):
  - Advances on each `din_dv` and wraps to 0 after `PKT_LEN`-1.
  - `sync_in` forces the accompanying sample (if `din_dv`) to be sample 0; otherwise the next sample is sample 0. `sync_in` has priority over normal advance.
- **Admission**, evaluated on each sample-0 cycle:
  - free = `FIFO_DEPTH` − (`wr_commit` − `rd_ptr`), using pointers one bit wider than the address.
  - free ≥ PB: ADMIT. Latch `din_chn` and set `wr_spec` = `wr_commit`.
  - Otherwise: DROP. The packet's samples are counted but not written; `stat_drop` pulses; `stat_drop_cnt` increments.
- **Packing:**
  - Sample k of a beat (k = `scnt` mod SPB) occupies bits [2*`IQ_WIDTH`*k +: 2*`IQ_WIDTH`], arranged as {`din_dr`, `din_di`] with real in the upper half.
  - On k = SPB−1 the beat, the sop flag (beat 0), the eop flag (beat PB−1) and the channel are written at `wr_spec`, and `wr_spec` increments.
- **Commit:** the eop-beat write also sets `wr_commit` = `wr_spec`+1. The read side sees only committed beats.
- **Abort:**
  - `sync_in` while an admitted packet is partial (`scnt` ≠ 0, or an admitted beat is pending) sets `wr_spec` = `wr_commit` and discards any gathered samples.
  - `stat_abort` pulses. `stat_drop_cnt` is unchanged.
  - `sync_in` at a packet boundary causes no abort.
- **Read side:**
  - The output register loads from the FIFO when (!`avst_source_valid` || `avst_source_ready`) and `rd_ptr` ≠ `wr_commit`.
  - Data, channel, sop and eop are held stable while valid && !ready.

## Timing
- All outputs are 0 during and after reset. All pointers and counters reset to 0; the first sample after reset is sample 0 of a packet.
- The beat write occurs in the cycle after the last sample of the beat is accepted.
- The last sample of a packet at cycle t gives the eop write at t+1, the commit at t+1, and the earliest sop `avst_source_valid` at t+3 when the FIFO was empty and ready is high.
- Sustained throughput is one beat per cycle with ready high.
- Full: admission guarantees that writes never overflow. Empty: valid deasserts after the last committed beat is consumed.
- Reset mid-packet or mid-output discards all FIFO contents immediately.

## Test plan
- **Basic packet:** SPB=4, PKT_LEN=8. Stream dr=n, di=−n for n=0..7 on chn 5 with ready high. Expect 2 beats; beat0 = {0,0,1,−1,2,−2,3,−3} packed (sample 0 in LSBs), sop=1 on beat 0, eop=1 on beat 1, channel=0x0005.
- **Backpressure:** ready toggles 1010…. Every beat is delivered exactly once, in order, with data stable during ready=0.
- **Drop:** FIFO_DEPTH=4, PB=2, ready low. Send 3 packets. Packets 1–2 are buffered. Packet 3 gives a `stat_drop` pulse and `stat_drop_cnt`=1. After ready goes high, exactly 4 beats are output.
- **Sync abort:** assert `sync_in` at sample 5 of an admitted 8-sample packet. `stat_abort`=1 and no beats of that packet are output. The sample carrying sync starts a new packet, which completes normally.
- **Sync on boundary:** `sync_in` with sample 0. No abort; output is identical to the basic packet case.
- **Saturation/reset:** force 65 540 drops. `stat_drop_cnt` holds 0xFFFF. Assert `rst_n` low mid-output: all outputs are 0 asynchronously, and the output stays empty after release.
